// File: rtl/cke_gen_pkg.sv
// Shared encodings and helpers for the multi-channel clock-enable generator.
package cke_gen_pkg;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_t;

  // Bits needed to hold value (at least one).
  function automatic int fBitWidth(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/cke_channel.sv
// One clock-enable channel: IDLE/RUN control, tick counter,
// divisor/mode latches and the registered enable pulse.
module cke_channel
  import cke_gen_pkg::*;
#(
  parameter int pDivWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [pDivWidth-1:0] div,
  input  logic                 mode,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hold,
  output logic                 cke,
  output logic                 busy
);

  ch_state_t            state;
  ch_state_t            state_nx;
  logic [pDivWidth-1:0] cnt;
  logic [pDivWidth-1:0] cnt_nx;
  logic [pDivWidth-1:0] div_q;
  logic [pDivWidth-1:0] div_nx;
  logic                 mode_q;
  logic                 mode_nx;
  logic                 cke_nx;
  logic                 count_en;
  logic                 hit;

  assign count_en = tick && !hold;
  assign hit      = count_en && (cnt == div_q);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    div_nx   = div_q;
    mode_nx  = mode_q;
    cke_nx   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_nx = ST_RUN;
          cnt_nx   = '0;
          div_nx   = div;
          mode_nx  = mode;
        end
      end
      ST_RUN: begin
        // stop beats start; restart never emits a pulse
        if (stop) begin
          state_nx = ST_IDLE;
        end else if (start) begin
          cnt_nx  = '0;
          div_nx  = div;
          mode_nx = mode;
        end else if (hit) begin
          cnt_nx = '0;
          cke_nx = 1'b1;
          if (mode_q == MODE_ONESHOT) begin
            state_nx = ST_IDLE;
          end
        end else if (count_en) begin
          cnt_nx = cnt + pDivWidth'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      div_q  <= '0;
      mode_q <= MODE_PERIODIC;
      cke    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      div_q  <= div_nx;
      mode_q <= mode_nx;
      cke    <= cke_nx;
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: rtl/multi_cke_generator.sv
// Shared free-running prescaler feeding pChNum independent
// clock-enable channels.
module multi_cke_generator
  import cke_gen_pkg::*;
#(
  parameter int pChNum    = 4,
  parameter int pDivWidth = 16,
  parameter int pPreDiv   = 1
) (
  input  logic                        iSysClk,
  input  logic                        iSysRst,
  input  logic [pChNum*pDivWidth-1:0] iDiv,
  input  logic [pChNum-1:0]           iMode,
  input  logic [pChNum-1:0]           iStart,
  input  logic [pChNum-1:0]           iStop,
  input  logic [pChNum-1:0]           iHold,
  output logic [pChNum-1:0]           oCke,
  output logic [pChNum-1:0]           oBusy,
  output logic                        oTick
);

  localparam int PreW = fBitWidth(pPreDiv - 1);

  logic [PreW-1:0] pre_cnt;
  logic            pre_wrap;

  // With pPreDiv=1 the count stays at 0 and wraps every cycle.
  assign pre_wrap = (pre_cnt == PreW'(pPreDiv - 1));

  always_ff @(posedge iSysClk) begin
    if (iSysRst) begin
      pre_cnt <= '0;
      oTick   <= 1'b0;
    end else begin
      oTick   <= pre_wrap;
      pre_cnt <= pre_wrap ? '0 : pre_cnt + PreW'(1);
    end
  end

  for (genvar g = 0; g < pChNum; g++) begin : g_ch
    cke_channel #(
      .pDivWidth(pDivWidth)
    ) u_ch (
      .clk  (iSysClk),
      .rst  (iSysRst),
      .tick (oTick),
      .div  (iDiv[g*pDivWidth +: pDivWidth]),
      .mode (iMode[g]),
      .start(iStart[g]),
      .stop (iStop[g]),
      .hold (iHold[g]),
      .cke  (oCke[g]),
      .busy (oBusy[g])
    );
  end

endmodule

// File: doc/multi_cke_generator.md
# multi_cke_generator

Multi-channel clock-enable generator: one shared free-running prescaler feeds `pChNum` independent channel dividers. Each channel has its own runtime divisor, a periodic or one-shot mode, start/stop control and a hold (pause) input. The block sits beside the system clock domain and supplies single-cycle enables to timers, LED/PWM engines, display refresh and debounce logic from one instance.

## Interface
- `pChNum`, 4: number of independent channels (1–16).
- `pDivWidth`, 16: width of each channel divisor and counter.
- `pPreDiv`, 1: shared prescaler ratio in `iSysClk` cycles per base tick (1 = tick every cycle).

Ports:
- `iSysClk`  in  1  system clock; the only clock.
- `iSysRst`  in  1  reset; synchronous, active-high.
- `iDiv`  in  `pChNum*pDivWidth`  per-channel divisor, channel n at `[n*pDivWidth +: pDivWidth]`; latched on start.
- `iMode`  in  `pChNum`  per channel: 0 = periodic, 1 = one-shot; latched on start.
- `iStart`  in  `pChNum`  single-cycle start/restart request per channel.
- `iStop`  in  `pChNum`  single-cycle stop request per channel.
- `iHold`  in  `pChNum`  level; freezes the channel counter while high.
- `oCke`  out  `pChNum`  registered single-cycle enable per channel.
- `oBusy`  out  `pChNum`  channel is in RUN.
- `oTick`  out  1  registered prescaler base tick.

## Operation
- Prescaler: counts 0..`pPreDiv`-1. `oTick` is high for one cycle each wrap. Reset clears the count. When `pPreDiv`=1, `oTick` is constantly high after reset.
- Per-channel state machine with two states, IDLE and RUN.
  - IDLE→RUN when `iStart` is sampled high. This clears the counter and latches `iDiv` and `iMode`.
  - RUN + `iStart` causes a restart: the counter is cleared and divisor and mode are relatched, with no `oCke` on that cycle.
  - RUN→IDLE when `iStop` is sampled high, with no `oCke` on that cycle. It also goes RUN→IDLE after the first match in one-shot mode.
  - `iStart` and `iStop` high together: stop wins and the channel goes to IDLE.
- Counting happens in RUN on cycles where `oTick`=1 and `iHold`=0:
  - If count equals the latched divisor, the count clears to 0 and `oCke` is asserted on the next cycle.
  - Otherwise the count increments by 1.
  - `iHold`=1 freezes the count and suppresses the match. The channel state is unaffected.
- Divisor 0 gives a match on every counted tick. With `pPreDiv`=1, this means `oCke` is continuously high in periodic mode.
- Period in periodic mode is (D+1)·`pPreDiv` cycles, where D is the latched divisor. Changes on `iDiv` during RUN have no effect until the next start.
- The counter never exceeds the latched divisor, so it cannot wrap.
- Channels are fully independent. All channels may fire on the same cycle.

## Timing
- Reset values: `oCke`=0, `oBusy`=0, `oTick`=0, all channels IDLE, all counters 0, latched divisor 0, latched mode periodic.
- Reset asserted mid-operation returns the block to these values on the next edge. Any `oCke` pending for that edge is dropped.
- `oBusy` rises on the edge that samples `iStart`. It falls on the edge that samples `iStop`, or on the one-shot match edge; in the one-shot case `oCke` and the fall of `oBusy` coincide.
- Worked timing, `pPreDiv`=1, divisor D, `iStart` sampled at edge 0:
  - The count is D at edge D+1, so `oCke` is high for the cycle after edge D+1.
  - Subsequent pulses follow every D+1 cycles.
- When `pPreDiv`>1, the prescaler is free-running and not reset by `iStart`. The first pulse therefore jitters by up to `pPreDiv`-1 cycles.
- `oCke` is never wider than one cycle, except when D=0 with `pPreDiv`=1.

## Structure
- Package `cke_gen_pkg` holds:
  - mode encoding constants (periodic / one-shot);
  - state encoding (IDLE, RUN);
  - the `fBitWidth` MSB-width function used to size the prescaler counter.
- Sub-module `cke_channel` contains one channel's FSM, counter and latches. It is instantiated `pChNum` times in a generate loop. The prescaler lives in the top level.

## Test plan
- Reset: `pPreDiv`=1. Assert `iSysRst` for 3 cycles → all outputs 0. Release, start channel 0 with D=4 → `oCke[0]` pulses at edges 5, 10, 15; `oBusy[0]`=1 throughout.
- One-shot: channel 1, D=2, mode 1 → a single `oCke[1]` at edge 3. `oBusy[1]` falls the same cycle and there are no further pulses for 20 cycles.
- Hold and prescaler: `pPreDiv`=3, D=1, hold asserted for 2 ticks mid-count → pulse spacing of 6 cycles, stretched by exactly 6 cycles during the hold.
- Start and stop together, then restart: stop and start together in RUN → IDLE with no pulse. Start with D=3, then restart at count 2 with D=1 → next pulse 2 cycles after the restart.
- Edge cases: D=0 periodic with `pPreDiv`=1 → `oCke` continuously high. Four channels with D=0,1,2,3 started together → all fire at edge 12. Reset mid-run → no `oCke` after reset.
